// File: rtl/led_snake_if.sv
// Signal bundle between the snake animator and its controller/frame transmitter.
// The controller side drives the animation controls; the animator drives frames and status.
interface led_snake_if;
    logic        new_frames_set_rqst;
    logic        enable;
    logic        dir;
    logic        bounce;
    logic [23:0] color;
    logic [15:0] step_period;
    logic [23:0] frame_for_led0;
    logic [23:0] frame_for_led1;
    logic [23:0] frame_for_led2;
    logic [23:0] frame_for_led3;
    logic [23:0] frame_for_led4;
    logic [23:0] frame_for_led5;
    logic [23:0] frame_for_led6;
    logic [23:0] frame_for_led7;
    logic [2:0]  head_pos;
    logic        step_pulse;
    logic        running;

    modport master (
        output new_frames_set_rqst, enable, dir, bounce, color, step_period,
        input  frame_for_led0, frame_for_led1, frame_for_led2, frame_for_led3,
               frame_for_led4, frame_for_led5, frame_for_led6, frame_for_led7,
               head_pos, step_pulse, running
    );

    modport slave (
        input  new_frames_set_rqst, enable, dir, bounce, color, step_period,
        output frame_for_led0, frame_for_led1, frame_for_led2, frame_for_led3,
               frame_for_led4, frame_for_led5, frame_for_led6, frame_for_led7,
               head_pos, step_pulse, running
    );
endinterface

// File: rtl/led_snake_animator.sv
// Snake animation on an 8-LED stripe: full-colour head plus a dimming tail.
// State and frames only move on the transmitter's frame-set request, so a set is never torn.
module led_snake_animator #(
    parameter logic [2:0] TAIL_LEN = 3'd3
) (
    input  logic       clk,
    input  logic       rstn,
    led_snake_if.slave bus
);

    typedef enum logic {OFF, RUN} state_t;

    state_t      state_q, state_d;
    logic [2:0]  head_q, head_d;
    logic        dir_q, dir_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] period_m1;
    logic        step_q, step_d;
    logic        load, clear;
    logic [23:0] frame_q [8];
    logic [23:0] frame_d [8];

    // Per-byte shift keeps each channel independent: no carry between R, G and B.
    function automatic logic [23:0] dim(input logic [23:0] c, input logic [2:0] d);
        return {c[23:16] >> d, c[15:8] >> d, c[7:0] >> d};
    endfunction

    function automatic logic [23:0] pixel(input logic [2:0] idx, input logic [2:0] head,
                                          input logic rev, input logic [23:0] c);
        logic [2:0] d;
        d = rev ? (idx - head) : (head - idx);
        if (d == 3'd0)
            return c;
        else if (d <= TAIL_LEN)
            return dim(c, d);
        else
            return 24'd0;
    endfunction

    assign period_m1 = (bus.step_period == 16'd0) ? 16'd0 : bus.step_period - 16'd1;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        step_d  = 1'b0;
        load    = 1'b0;
        clear   = 1'b0;
        if (bus.new_frames_set_rqst) begin
            unique case (state_q)
                OFF: begin
                    if (bus.enable) begin
                        state_d = RUN;
                        dir_d   = bus.dir;
                        head_d  = bus.dir ? 3'd7 : 3'd0;
                        cnt_d   = 16'd0;
                        load    = 1'b1;
                    end
                end
                RUN: begin
                    if (!bus.enable) begin
                        state_d = OFF;
                        head_d  = 3'd0;
                        cnt_d   = 16'd0;
                        clear   = 1'b1;
                    end else if (cnt_q >= period_m1) begin
                        // >= so a shortened period forces a step instead of waiting for a wrap
                        cnt_d  = 16'd0;
                        step_d = 1'b1;
                        load   = 1'b1;
                        if (!bus.bounce) begin
                            dir_d  = bus.dir;
                            head_d = bus.dir ? head_q - 3'd1 : head_q + 3'd1;
                        end else if (head_q == 3'd7 && !dir_q) begin
                            dir_d  = 1'b1;
                            head_d = 3'd6;
                        end else if (head_q == 3'd0 && dir_q) begin
                            dir_d  = 1'b0;
                            head_d = 3'd1;
                        end else begin
                            head_d = dir_q ? head_q - 3'd1 : head_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: state_d = OFF;
            endcase
        end
        for (int i = 0; i < 8; i++) begin
            if (clear)
                frame_d[i] = 24'd0;
            else if (load)
                frame_d[i] = pixel(3'(i), head_d, dir_d, bus.color);
            else
                frame_d[i] = frame_q[i];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= OFF;
            head_q  <= 3'd0;
            dir_q   <= 1'b0;
            cnt_q   <= 16'd0;
            step_q  <= 1'b0;
            for (int i = 0; i < 8; i++) frame_q[i] <= 24'd0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            for (int i = 0; i < 8; i++) frame_q[i] <= frame_d[i];
        end
    end

    assign bus.frame_for_led0 = frame_q[0];
    assign bus.frame_for_led1 = frame_q[1];
    assign bus.frame_for_led2 = frame_q[2];
    assign bus.frame_for_led3 = frame_q[3];
    assign bus.frame_for_led4 = frame_q[4];
    assign bus.frame_for_led5 = frame_q[5];
    assign bus.frame_for_led6 = frame_q[6];
    assign bus.frame_for_led7 = frame_q[7];
    assign bus.head_pos       = head_q;
    assign bus.step_pulse     = step_q;
    assign bus.running        = (state_q == RUN);

endmodule

// File: tb/tb_led_snake_animator.sv
// Bench for led_snake_animator: directed scenarios plus random traffic, all checked
// against a behavioural model of the snake kept in plain integers.
module tb_led_snake_animator;

    localparam int TAIL = 3;

    logic clk;
    logic rstn;

    led_snake_if bus ();

    led_snake_animator #(.TAIL_LEN(3'd3)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [23:0] got_f [8];
    assign got_f[0] = bus.frame_for_led0;
    assign got_f[1] = bus.frame_for_led1;
    assign got_f[2] = bus.frame_for_led2;
    assign got_f[3] = bus.frame_for_led3;
    assign got_f[4] = bus.frame_for_led4;
    assign got_f[5] = bus.frame_for_led5;
    assign got_f[6] = bus.frame_for_led6;
    assign got_f[7] = bus.frame_for_led7;

    int n_checks;
    int n_errors;

    // Reference model: snake described by run flag, head index, direction, refresh count
    bit          m_run;
    int          m_head;
    int          m_dir;
    int          m_cnt;
    bit          m_step;
    logic [23:0] m_frames [8];

    task automatic check_val(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] m_pixel(input int i, input int head, input int dir,
                                            input logic [23:0] c);
        int d;
        logic [23:0] r;
        d = dir ? (i - head) : (head - i);
        d = (d + 8) % 8;
        r = 24'd0;
        if (d == 0) begin
            r = c;
        end else if (d <= TAIL) begin
            for (int ch = 0; ch < 3; ch++) begin
                int b;
                b = (int'(c) >> (8 * ch)) & 255;
                b = b >> d;
                r = r | 24'(b << (8 * ch));
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        m_run  = 0;
        m_head = 0;
        m_dir  = 0;
        m_cnt  = 0;
        m_step = 0;
        for (int i = 0; i < 8; i++) m_frames[i] = 24'd0;
    endtask

    task automatic model_load();
        for (int i = 0; i < 8; i++) m_frames[i] = m_pixel(i, m_head, m_dir, bus.color);
    endtask

    task automatic model_edge();
        int per;
        m_step = 0;
        if (!rstn || !bus.new_frames_set_rqst) return;
        per = (bus.step_period == 16'd0) ? 1 : int'(bus.step_period);
        if (!m_run) begin
            if (bus.enable) begin
                m_run  = 1;
                m_dir  = int'(bus.dir);
                m_head = bus.dir ? 7 : 0;
                m_cnt  = 0;
                model_load();
            end
        end else if (!bus.enable) begin
            m_run  = 0;
            m_head = 0;
            m_cnt  = 0;
            for (int i = 0; i < 8; i++) m_frames[i] = 24'd0;
        end else if (m_cnt >= per - 1) begin
            m_cnt  = 0;
            m_step = 1;
            if (bus.bounce) begin
                if (m_head == 7 && m_dir == 0) begin
                    m_dir = 1; m_head = 6;
                end else if (m_head == 0 && m_dir == 1) begin
                    m_dir = 0; m_head = 1;
                end else begin
                    m_head = m_head + (m_dir ? -1 : 1);
                end
            end else begin
                m_dir  = int'(bus.dir);
                m_head = (m_head + (m_dir ? 7 : 1)) % 8;
            end
            model_load();
        end else begin
            m_cnt++;
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int i = 0; i < 8; i++)
            check_val($sformatf("%s led%0d", tag, i), got_f[i], m_frames[i]);
        check_val({tag, " head_pos"}, 24'(bus.head_pos), 24'(m_head));
        check_val({tag, " step_pulse"}, 24'(bus.step_pulse), 24'(m_step));
        check_val({tag, " running"}, 24'(bus.running), 24'(m_run));
    endtask

    // One clock: model follows the DUT edge, outputs compared on the falling edge
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic rqst_pulse(input string tag);
        bus.new_frames_set_rqst = 1'b1;
        tick(tag);
        bus.new_frames_set_rqst = 1'b0;
        tick(tag);
    endtask

    task automatic async_reset(input string tag);
        #2 rstn = 1'b0;
        #1 model_reset();
        check_outputs(tag);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    int steps_seen;

    initial begin
        n_checks = 0;
        n_errors = 0;
        bus.new_frames_set_rqst = 1'b0;
        bus.enable      = 1'b0;
        bus.dir         = 1'b0;
        bus.bounce      = 1'b0;
        bus.color       = 24'h000000;
        bus.step_period = 16'd1;
        rstn = 1'b1;
        model_reset();
        #2 rstn = 1'b0;
        #1 check_outputs("reset");
        @(negedge clk);
        rstn = 1'b1;
        tick("idle");

        // First load: snake at LED 0 with tail wrapping to 7, 6, 5
        bus.enable = 1'b1;
        bus.color  = 24'hFF8040;
        bus.new_frames_set_rqst = 1'b1;
        tick("start");
        bus.new_frames_set_rqst = 1'b0;
        check_val("start led0", got_f[0], 24'hFF8040);
        check_val("start led7", got_f[7], 24'h7F4020);
        check_val("start led6", got_f[6], 24'h3F2010);
        check_val("start led5", got_f[5], 24'h1F1008);
        check_val("start led1", got_f[1], 24'h000000);
        check_val("start head", 24'(bus.head_pos), 24'd0);
        check_val("start running", 24'(bus.running), 24'd1);
        tick("start hold");

        for (int k = 1; k <= 9; k++) begin
            bus.new_frames_set_rqst = 1'b1;
            tick("wrap");
            bus.new_frames_set_rqst = 1'b0;
            check_val($sformatf("wrap head %0d", k), 24'(bus.head_pos), 24'(k % 8));
            check_val("wrap step", 24'(bus.step_pulse), 24'd1);
            tick("wrap gap");
        end

        // Move to head 5, then bounce off the top end
        for (int k = 0; k < 4; k++) rqst_pulse("to5");
        bus.bounce = 1'b1;
        rqst_pulse("bounce");
        rqst_pulse("bounce");
        rqst_pulse("bounce");
        check_val("bounce head6", 24'(bus.head_pos), 24'd6);
        check_val("bounce led7 dim", got_f[7], 24'h7F4020);
        rqst_pulse("bounce");
        check_val("bounce head5", 24'(bus.head_pos), 24'd5);

        // Slower stepping: one step every third refresh
        bus.bounce = 1'b0;
        bus.step_period = 16'd3;
        steps_seen = 0;
        for (int k = 0; k < 9; k++) begin
            bus.new_frames_set_rqst = 1'b1;
            tick("period3");
            bus.new_frames_set_rqst = 1'b0;
            if (bus.step_pulse) steps_seen++;
            tick("period3 gap");
        end
        check_val("period3 steps", 24'(steps_seen), 24'd3);
        bus.step_period = 16'd0;
        for (int k = 0; k < 3; k++) rqst_pulse("period0");

        // Disable on a step-due request, then hold with no request
        bus.step_period = 16'd1;
        bus.enable = 1'b0;
        rqst_pulse("disable");
        check_val("disable running", 24'(bus.running), 24'd0);
        bus.enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.color = $urandom;
            bus.dir   = ~bus.dir;
            tick("hold");
        end
        rqst_pulse("restart");
        rqst_pulse("restart");

        // Asynchronous reset between requests, then restart in reverse
        async_reset("midreset");
        bus.dir = 1'b1;
        rqst_pulse("after reset");
        check_val("after reset head7", 24'(bus.head_pos), 24'd7);

        // Random traffic
        for (int k = 0; k < 1500; k++) begin
            bus.new_frames_set_rqst = 1'($urandom_range(0, 1));
            bus.enable      = ($urandom_range(0, 9) != 0);
            bus.dir         = 1'($urandom_range(0, 1));
            bus.bounce      = 1'($urandom_range(0, 1));
            bus.color       = 24'($urandom);
            bus.step_period = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) async_reset("rand reset");
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/led_snake_animator.md
Name: led_snake_animator

Overview:
- Animation sequencer that generates the eight 24-bit LED colour frames consumed by the frame transmitter.
- Draws a moving "snake" on the 8-LED stripe: a full-colour head followed by a dimming tail.
- Advances the snake once every step_period frame-set refreshes.
- Updates its frame registers only on the transmitter's new_frames_set_rqst pulse, so a frame set is never torn mid-transmission.

Parameters:
TAIL_LEN, 3'd3, number of tail LEDs behind the head (0..7); tail LED at distance d shows colour with each 8-bit channel shifted right by d.

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
new_frames_set_rqst  in  1  one-cycle pulse from frame transmitter: full set consumed, next set may be loaded
enable  in  1  1 = animate, 0 = blank stripe
dir  in  1  0 = head moves toward higher LED index, 1 = toward lower
bounce  in  1  1 = reverse at stripe ends, 0 = wrap around
color  in  24  head colour, channel order as frame_for_ledN
step_period  in  16  refreshes per snake step; 0 treated as 1
frame_for_led0..frame_for_led7  out  24 each  colour frames to frame transmitter
head_pos  out  3  current head index
step_pulse  out  1  one-cycle pulse when head advances
running  out  1  1 while in RUN state

Behaviour:
- Reset (rstn low, asynchronous):
  - all frame outputs 0; head_pos 0; internal direction dir_r 0; refresh counter 0.
  - state OFF; step_pulse 0; running 0.
- Registered update: all state changes occur only on a clock edge with new_frames_set_rqst=1 ("rqst edge"). Without a rqst, every output holds, regardless of input changes.
- FSM states and transitions:
  - OFF, rqst edge, enable=1: go to RUN.
    - dir_r<=dir; head<=0 if dir=0 else 7; counter<=0.
    - Frames loaded with the snake at the start position; step_pulse stays 0.
  - OFF, rqst edge, enable=0: frames stay 0.
  - RUN, rqst edge, enable=0: go to OFF; all frames<=0; head<=0; counter<=0. Blanking wins over any step due on the same edge.
  - RUN, rqst edge, enable=1, counter < max(step_period,1)-1: counter<=counter+1; frames unchanged.
  - RUN, rqst edge, enable=1, counter = max(step_period,1)-1: counter<=0; step_pulse=1 for the following cycle; head advances; frames recomputed in the same edge.
- Step rules:
  - bounce=0: dir_r<=dir sampled at the step; head moves +1 (dir_r=0) or -1 (dir_r=1), wrapping modulo 8 (7->0, 0->7).
  - bounce=1: dir_r ignores dir. At head=7 with dir_r=0, dir_r flips to 1 and head goes to 6; at head=0 with dir_r=1, dir_r flips to 0 and head goes to 1. Otherwise head moves normally.
- Frame computation (uses new head, new dir_r, color sampled at the same edge):
  - d = (head-i) mod 8 when dir_r=0; d = (i-head) mod 8 when dir_r=1.
  - d=0: color.
  - 1<=d<=TAIL_LEN: {R>>d, G>>d, B>>d}, per-byte shift, no inter-byte carry.
  - otherwise: 0. Tail positions wrap modulo 8 in both modes.
- Mid-step changes: a step_period change takes effect at the next comparison. If counter already exceeds the new period-1, the next rqst edge forces a step (compare is >=). A color change is visible only at the next step or OFF->RUN load.
- Latency: frame outputs, head_pos and running change one clock after the rqst edge (registered). step_pulse is high exactly that cycle.
- Reset mid-run clears everything immediately, with no wait for a rqst edge.

Test Plan:
- Reset, enable=1, dir=0, bounce=0, color=24'hFF8040, step_period=1, TAIL_LEN=3, one rqst -> head_pos=0, running=1, led0=FF8040, led7=7F4020, led6=3F2010, led5=1F1008, others 0, step_pulse stays 0.
- Same setup, 9 further rqst pulses -> head_pos 1,2,...,7,0,1; step_pulse high once per rqst; wrap 7->0 correct.
- bounce=1, step_period=1, run from head 5 -> head_pos sequence 6,7,6,5 with dir_r flip at 7; at head 6 after the flip, led7 = color>>1.
- step_period=3, 9 rqst pulses -> exactly 3 step_pulses, on rqst 3, 6, 9; frames constant between steps; step_period=0 behaves as 1.
- enable dropped in RUN simultaneous with a step-due rqst -> all frames 0, head_pos 0, running 0, no step_pulse; with no rqst, outputs hold despite color/dir toggling.
- rstn asserted mid-run between rqst pulses -> all outputs 0 asynchronously; after release, first rqst with enable=1, dir=1 gives head_pos=7.
